xc_aessub_mc: RTL and testbench

- Parametrised AES SubBytes functional unit for the XCrypto execute stage. Implements forward and inverse SubBytes, with optional byte rotation.
- S-box lane count (LANES) is configurable, trading area against latency. An optional output register (OUT_REG) breaks the S-box critical path.
- Uses a valid/ready handshake with flush and abort, so it can sit behind a multi-cycle issue slot.

---
 rtl/xc_aessub_pkg.sv | 52 +++++
 rtl/xc_aessub_sbox.sv | 12 +
 rtl/xc_aessub_mc.sv | 120 ++++++++++++
 tb/tb_xc_aessub_mc.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/xc_aessub_pkg.sv
// Shared constants and GF(2^8) helpers for the XCrypto AES SubBytes unit.
package xc_aessub_pkg;

    // Bytes 1 and 3 come from rs2, bytes 0 and 2 from rs1.
    localparam logic [3:0]      BYTE_FROM_RS2 = 4'b1010;
    localparam logic [3:0][4:0] BYTE_LSB      = {5'd24, 5'd16, 5'd8, 5'd0};

    // With rot=1, result byte j takes composed byte ROT_SRC[j].
    localparam logic [3:0][1:0] ROT_SRC = {2'd2, 2'd1, 2'd0, 2'd3};

    function automatic int beats_of(input int lanes);
        return 4 / lanes;
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse, and maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        return gf_mul(x252, x2);
    endfunction

    function automatic logic [7:0] affine_fwd(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] affine_inv(input logic [7:0] s);
        return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    endfunction

endpackage

// File: rtl/xc_aessub_sbox.sv
// Combinational AES S-box, forward (enc=1) or inverse (enc=0).
module xc_aessub_sbox
    import xc_aessub_pkg::*;
(
    input  logic [7:0] data,
    input  logic       enc,
    output logic [7:0] sub
);

    assign sub = enc ? affine_fwd(gf_inv(data)) : gf_inv(affine_inv(data));

endmodule

// File: rtl/xc_aessub_mc.sv
// Multi-cycle AES SubBytes unit: LANES S-boxes processed over 4/LANES beats.
module xc_aessub_mc
    import xc_aessub_pkg::*;
#(
    parameter int LANES   = 4,
    parameter bit OUT_REG = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        valid,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        enc,
    input  logic        rot,
    output logic        ready,
    output logic [31:0] result
);

    localparam int         BEATS    = beats_of(LANES);
    localparam int         LIVE_LSB = (BEATS - 1) * LANES;
    localparam logic [1:0] LAST     = 2'(BEATS - 1);

    logic [1:0]             beat_reg, beat_next;
    logic                   done_reg, done_next;
    logic                   advance;
    logic                   last_beat;
    logic [3:0][7:0]        in_byte;
    logic [LANES-1:0][7:0]  lane_in;
    logic [LANES-1:0][7:0]  lane_out;
    logic [3:0][7:0]        word;
    logic [3:0][7:0]        rot_word;

    assign last_beat = valid && !flush && !done_reg && (beat_reg == LAST);
    assign advance   = valid && !flush && !done_reg && (beat_reg != LAST);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sel
            logic [31:0] src;
            assign src         = BYTE_FROM_RS2[gi] ? rs2 : rs1;
            assign in_byte[gi] = src[BYTE_LSB[gi] +: 8];
        end

        // Inputs are gated with valid so the S-boxes stay quiet while idle.
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [1:0] sel;
            assign sel          = 2'(int'(beat_reg) * LANES + gi);
            assign lane_in[gi]  = in_byte[sel] & {8{valid}};
            xc_aessub_sbox u_sbox (
                .data (lane_in[gi]),
                .enc  (enc),
                .sub  (lane_out[gi])
            );
        end

        // Bytes from earlier beats are staged; the last beat's bytes stay live.
        for (gi = 0; gi < 4; gi++) begin : g_byte
            if (gi < LIVE_LSB) begin : g_stage
                logic [7:0] b_reg;
                always_ff @(posedge clock) begin
                    if (reset) begin
                        b_reg <= 8'h00;
                    end else if (advance && (beat_reg == 2'(gi / LANES))) begin
                        b_reg <= lane_out[gi % LANES];
                    end
                end
                assign word[gi] = b_reg;
            end else begin : g_live
                assign word[gi] = lane_out[gi - LIVE_LSB];
            end
        end

        for (gi = 0; gi < 4; gi++) begin : g_rot
            assign rot_word[gi] = rot ? word[ROT_SRC[gi]] : word[gi];
        end
    endgenerate

    always_comb begin
        beat_next = beat_reg;
        done_next = 1'b0;
        if (flush || done_reg || !valid) begin
            beat_next = 2'd0;
        end else if (beat_reg == LAST) begin
            beat_next = 2'd0;
            done_next = OUT_REG;
        end else begin
            beat_next = beat_reg + 2'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            beat_reg <= 2'd0;
            done_reg <= 1'b0;
        end else begin
            beat_reg <= beat_next;
            done_reg <= done_next;
        end
    end

    generate
        if (OUT_REG) begin : g_out_reg
            logic [31:0] result_reg;
            always_ff @(posedge clock) begin
                if (reset) begin
                    result_reg <= 32'h0;
                end else if (last_beat) begin
                    result_reg <= rot_word;
                end
            end
            assign ready  = done_reg && !flush && !reset;
            assign result = ready ? result_reg : 32'h0;
        end else begin : g_out_comb
            assign ready  = last_beat && !reset;
            assign result = ready ? rot_word : 32'h0;
        end
    endgenerate

endmodule

// File: tb/tb_xc_aessub_mc.sv
// Directed bench for xc_aessub_mc across four LANES/OUT_REG configurations.
module tb_xc_aessub_mc;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic [31:0] rs1, rs2;
    logic        enc, rot;
    logic [3:0]  valid_v;
    logic [3:0]  ready_v;
    logic [31:0] result_v [4];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clock = ~clock;

    // 0: LANES=4/comb, 1: LANES=1/registered, 2: LANES=2/comb, 3: LANES=1/comb
    xc_aessub_mc #(.LANES(4), .OUT_REG(1'b0)) u_l4 (
        .clock(clock), .reset(reset), .flush(flush), .valid(valid_v[0]),
        .rs1(rs1), .rs2(rs2), .enc(enc), .rot(rot),
        .ready(ready_v[0]), .result(result_v[0]));
    xc_aessub_mc #(.LANES(1), .OUT_REG(1'b1)) u_l1r (
        .clock(clock), .reset(reset), .flush(flush), .valid(valid_v[1]),
        .rs1(rs1), .rs2(rs2), .enc(enc), .rot(rot),
        .ready(ready_v[1]), .result(result_v[1]));
    xc_aessub_mc #(.LANES(2), .OUT_REG(1'b0)) u_l2 (
        .clock(clock), .reset(reset), .flush(flush), .valid(valid_v[2]),
        .rs1(rs1), .rs2(rs2), .enc(enc), .rot(rot),
        .ready(ready_v[2]), .result(result_v[2]));
    xc_aessub_mc #(.LANES(1), .OUT_REG(1'b0)) u_l1 (
        .clock(clock), .reset(reset), .flush(flush), .valid(valid_v[3]),
        .rs1(rs1), .rs2(rs2), .enc(enc), .rot(rot),
        .ready(ready_v[3]), .result(result_v[3]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Entered just after a rising edge; returns just after the edge that ends the ready cycle.
    task automatic run_op(input string tag, input int d, input logic [31:0] a,
                          input logic [31:0] b, input logic e, input logic r,
                          input logic [31:0] exp, input int lat, input bit keep);
        int found;
        logic [31:0] got;
        found = -1;
        got   = 32'h0;
        rs1 = a; rs2 = b; enc = e; rot = r;
        valid_v[d] = 1'b1;
        for (int c = 0; c < lat + 4 && found < 0; c++) begin
            @(negedge clock);
            if (ready_v[d]) begin
                found = c;
                got   = result_v[d];
                chk({tag, "_res"}, result_v[d], exp);
            end else begin
                chk({tag, "_zero"}, result_v[d], 32'h0);
            end
            @(posedge clock); #1;
        end
        chk({tag, "_lat"}, 32'(found), 32'(lat));
        if (!keep) valid_v[d] = 1'b0;
        $display("op %s dut%0d rs1=%h rs2=%h enc=%0d rot=%0d result=%h latency=%0d",
                 tag, d, a, b, e, r, got, found);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; valid_v = 4'b0;
        rs1 = 32'h0; rs2 = 32'h0; enc = 1'b1; rot = 1'b0;
        @(posedge clock); #1;
        @(negedge clock);
        chk("rst_ready", 32'(ready_v), 32'h0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        for (int d = 0; d < 4; d++) begin
            chk("idle_ready", 32'(ready_v[d]), 32'h0);
            chk("idle_result", result_v[d], 32'h0);
        end
        @(posedge clock); #1;

        // Fully combinational, forward, with and without rotation
        run_op("l4_fwd", 0, 32'h00530001, 32'hFF000000, 1'b1, 1'b0, 32'h16ED637C, 0, 1'b0);
        run_op("l4_rot", 0, 32'h00530001, 32'hFF000000, 1'b1, 1'b1, 32'hED637C16, 0, 1'b0);
        run_op("l1r_rot", 1, 32'h00530001, 32'hFF000000, 1'b1, 1'b1, 32'hED637C16, 4, 1'b0);
        run_op("l2_inv", 2, 32'h00ED007C, 32'h16006300, 1'b0, 1'b0, 32'hFF530001, 1, 1'b0);
        @(negedge clock);
        chk("l2_after", result_v[2], 32'h0);
        @(posedge clock); #1;

        // Back-to-back with valid held high, alternating operands
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0)
                run_op("b2b_a", 3, 32'h00530001, 32'hFF000000, 1'b1, 1'b0, 32'h16ED637C, 3, i < 5);
            else
                run_op("b2b_b", 3, 32'h00ED007C, 32'h16006300, 1'b0, 1'b0, 32'hFF530001, 3, i < 5);
        end

        // Flush on beat 2, then a fresh operation
        rs1 = 32'h00530001; rs2 = 32'hFF000000; enc = 1'b1; rot = 1'b0;
        valid_v[3] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            flush = (c == 2);
            @(negedge clock);
            chk("flush_ready", 32'(ready_v[3]), 32'h0);
            @(posedge clock); #1;
        end
        flush = 1'b0;
        run_op("post_flush", 3, 32'h0, 32'h0, 1'b1, 1'b0, 32'h63636363, 3, 1'b0);

        // Abort by dropping valid at beat 1
        rs1 = 32'h00530001; rs2 = 32'hFF000000;
        valid_v[3] = 1'b1;
        for (int c = 0; c < 2; c++) begin
            valid_v[3] = (c == 0);
            @(negedge clock);
            chk("abort_ready", 32'(ready_v[3]), 32'h0);
            @(posedge clock); #1;
        end
        run_op("post_abort", 3, 32'h0, 32'h0, 1'b1, 1'b0, 32'h63636363, 3, 1'b0);

        // Reset while the registered unit sits in DONE
        rs1 = 32'h00530001; rs2 = 32'hFF000000; enc = 1'b1; rot = 1'b0;
        valid_v[1] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            reset = (c == 4);
            @(negedge clock);
            chk("rstmid_ready", 32'(ready_v[1]), 32'h0);
            chk("rstmid_result", result_v[1], 32'h0);
            @(posedge clock); #1;
        end
        reset = 1'b0;
        valid_v[1] = 1'b0;
        @(negedge clock);
        chk("post_rst_ready", 32'(ready_v[1]), 32'h0);
        chk("post_rst_result", result_v[1], 32'h0);
        @(posedge clock); #1;
        run_op("post_rst", 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h16161616, 4, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
